// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle for serial_add_ctrl: the requester drives the
// operands and controls, the adder returns status and the result.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, abort, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, abort, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: a+b+cin computed LSB first through one shared 1-bit full
// adder, one bit per clock, sequenced by a three-state IDLE/RUN/DONE FSM.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int                IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             fa_s;
  logic             fa_cout;

  full_adder u_fa (
    .A    (a_reg[idx]),
    .B    (b_reg[idx]),
    .Cin  (carry),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  // NOTE: every register here is written with <= so all updates on an edge
  // see the pre-edge values (e.g. ovf uses the old carry, not fa_cout).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
            carry <= bus.cin;
            sum_r <= '0;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state <= IDLE;
          end else begin
            sum_r[idx] <= fa_s;
            carry      <= fa_cout;
            if (idx == LAST_IDX) begin
              // Carry into the MSB is the old carry; XOR with carry out flags
              // signed overflow. idx holds at WIDTH-1 so it never overruns.
              cout_r <= fa_cout;
              ovf_r  <= carry ^ fa_cout;
              state  <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
endmodule

module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, which sets the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1 bit: cancels an addition in progress.
REQ-006 The block SHALL have ports a and b, inputs, WIDTH bits each: the addend operands, captured when start is accepted.
REQ-007 The block SHALL have port cin, input, 1 bit: the carry-in, captured when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse, high while in DONE.
REQ-010 The block SHALL have port sum, output, WIDTH bits: the result register.
REQ-011 The block SHALL have port cout, output, 1 bit: the final carry-out.
REQ-012 The block SHALL have port ovf, output, 1 bit: the two's-complement overflow flag.

Function
REQ-013 The block SHALL compute a+b+cin bit-serially, LSB first, through exactly one instance of the team's 1-bit full adder (inputs A, B, Cin; outputs S, Cout).
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 On an edge in IDLE with start=1 and abort=0, the block SHALL:
- latch a, b and cin into the operand and carry registers;
- clear sum and the bit index;
- go to RUN.
REQ-016 In IDLE with start=0, or with start=1 and abort=1, the block SHALL stay in IDLE with every register unchanged.
REQ-017 On each RUN edge, the block SHALL:
- write the full-adder S into sum[idx];
- load the full-adder Cout into the carry register;
- increment idx.
The full-adder inputs are a_reg[idx], b_reg[idx] and the carry register.
REQ-018 On the RUN edge where idx=WIDTH-1, the block SHALL:
- load cout from the full-adder Cout;
- load ovf from (carry register XOR full-adder Cout), i.e. the carry into the MSB XOR the carry out;
- go to DONE.
REQ-019 Latency SHALL be exact: with the start-capture edge numbered 0, RUN occupies edges 1..WIDTH and done is high for the cycle that follows edge WIDTH.
REQ-020 DONE SHALL last exactly one cycle, then go unconditionally to IDLE; a start present during DONE SHALL be ignored.
REQ-021 busy SHALL be high exactly in RUN; done SHALL be high exactly in DONE; busy and done SHALL never be high together.
REQ-022 start SHALL be ignored in RUN and DONE; operand registers SHALL NOT change outside the capture edge.
REQ-023 abort=1 on a RUN edge SHALL take precedence over the bit operation:
- go to IDLE, with no done pulse;
- leave sum, cout and ovf unspecified until the next completed addition.
REQ-024 abort SHALL have no effect in IDLE or DONE.
REQ-025 sum, cout and ovf SHALL hold their last completed values through IDLE until the next accepted start; sum is cleared at that start.
REQ-026 The idx counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never exceed WIDTH-1.
REQ-027 A back-to-back start is allowed: a start sampled in the IDLE cycle immediately after DONE SHALL be accepted, giving one addition every WIDTH+2 cycles.

Reset
REQ-028 rst_n=0 SHALL immediately, independent of clk:
- force state to IDLE;
- clear busy, done, sum, cout, ovf, idx, the operand registers and the carry register to 0.
REQ-029 A reset asserted mid-RUN SHALL discard the operation with no done pulse; after rst_n rises, the first edge with start=1 SHALL begin a fresh addition.
REQ-030 Outputs SHALL be 0 from reset until the first done pulse.

Verification (WIDTH=8)
REQ-031 a=0x5A, b=0x33, cin=0, start for one cycle: busy high for 8 cycles, then done for 1 cycle with sum=0x8D, cout=0, ovf=1.
REQ-032 a=0xFF, b=0x01, cin=0: sum=0x00, cout=1, ovf=0; then a=0x7F, b=0x00, cin=1 started the cycle after done: sum=0x80, cout=0, ovf=1, and the second done comes 10 cycles after the first.
REQ-033 start held high continuously with the operands changed mid-RUN: the result uses only the operands captured at the first edge, and the next capture occurs in the IDLE cycle after done.
REQ-034 abort=1 on RUN edge 4: busy drops, no done pulse, state IDLE; a following a=0x01, b=0x01 addition gives sum=0x02.
REQ-035 rst_n pulsed low asynchronously mid-RUN (between edges): all outputs go to 0 at once with no done pulse; the addition after release is correct.
REQ-036 Exhaustive random check against a+b+cin across 1000 operations, including cin=1 and 0x80+0x80 (expect sum=0x00, cout=1, ovf=1).
